// File: rtl/uart_dmi_ctrl.sv
// UART byte-frame to DMI bridge: 01/02 frames -> one DMI read/write, reply status (+4 read-data bytes, LSB first).
// DMI request 1 cycle after last frame byte, first reply byte 1 cycle after response; stalls are held in the UART FIFOs or DMI handshakes.
module uart_dmi_ctrl #(
    parameter int ABITS   = 7,
    parameter int TIMEOUT = 100000
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             RX_EMPTY_I,
    output logic             RE_O,
    input  logic [7:0]       DREC_I,
    input  logic             TX_READY_I,
    output logic             WE_O,
    output logic [7:0]       DSEND_O,
    output logic             DMI_REQ_VALID_O,
    input  logic             DMI_REQ_READY_I,
    output logic [ABITS-1:0] DMI_REQ_ADDR_O,
    output logic [31:0]      DMI_REQ_DATA_O,
    output logic [1:0]       DMI_REQ_OP_O,
    input  logic             DMI_RESP_VALID_I,
    output logic             DMI_RESP_READY_O,
    input  logic [31:0]      DMI_RESP_DATA_I,
    input  logic [1:0]       DMI_RESP_OP_I,
    output logic             BUSY_O
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_ADDR,
        S_RX_DATA,
        S_DMI_REQ,
        S_DMI_RESP,
        S_TX_STATUS,
        S_TX_DATA
    } state_t;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t           state;
    logic [1:0]       op;
    logic [1:0]       idx;
    logic [TW-1:0]    tmo_cnt;
    logic [ABITS-1:0] addr;
    logic [31:0]      req_data;
    logic [31:0]      resp_data;
    logic [7:0]       status;
    logic             rx_state;
    logic             tx_state;

    assign rx_state = (state == S_IDLE) || (state == S_RX_ADDR) || (state == S_RX_DATA);
    assign tx_state = (state == S_TX_STATUS) || (state == S_TX_DATA);

    // RX byte is taken straight from the FIFO head in the cycle it is strobed.
    assign RE_O = rx_state && !RX_EMPTY_I && !RST_I;
    assign WE_O = tx_state && TX_READY_I && !RST_I;

    assign DMI_REQ_VALID_O  = (state == S_DMI_REQ);
    assign DMI_RESP_READY_O = (state == S_DMI_RESP);
    assign DMI_REQ_ADDR_O   = addr;
    assign DMI_REQ_DATA_O   = req_data;
    assign DMI_REQ_OP_O     = op;
    assign BUSY_O           = (state != S_IDLE);

    always_comb begin
        DSEND_O = status;
        if (state == S_TX_DATA) begin
            case (idx)
                2'd0:    DSEND_O = resp_data[7:0];
                2'd1:    DSEND_O = resp_data[15:8];
                2'd2:    DSEND_O = resp_data[23:16];
                default: DSEND_O = resp_data[31:24];
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state     <= S_IDLE;
            op        <= 2'd0;
            idx       <= 2'd0;
            tmo_cnt   <= '0;
            addr      <= '0;
            req_data  <= '0;
            resp_data <= '0;
            status    <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (RE_O) begin
                        case (DREC_I)
                            8'h00: ;
                            8'h01, 8'h02: begin
                                op       <= DREC_I[1:0];
                                req_data <= '0;
                                state    <= S_RX_ADDR;
                            end
                            default: begin
                                op     <= 2'd0;
                                status <= 8'hFF;
                                state  <= S_TX_STATUS;
                            end
                        endcase
                    end
                end
                S_RX_ADDR, S_RX_DATA: begin
                    if (RE_O) begin
                        tmo_cnt <= '0;
                        if (state == S_RX_ADDR) begin
                            addr  <= DREC_I[ABITS-1:0];
                            idx   <= 2'd0;
                            state <= (op == 2'd1) ? S_DMI_REQ : S_RX_DATA;
                        end else begin
                            // Shift in from the top so the first byte lands in [7:0].
                            req_data <= {DREC_I, req_data[31:8]};
                            idx      <= idx + 1'b1;
                            if (idx == 2'd3) state <= S_DMI_REQ;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DMI_REQ: begin
                    if (DMI_REQ_READY_I) state <= S_DMI_RESP;
                end
                S_DMI_RESP: begin
                    if (DMI_RESP_VALID_I) begin
                        resp_data <= DMI_RESP_DATA_I;
                        status    <= {6'b0, DMI_RESP_OP_I};
                        state     <= S_TX_STATUS;
                    end
                end
                S_TX_STATUS: begin
                    if (TX_READY_I) begin
                        idx   <= 2'd0;
                        state <= (op == 2'd1 && status == 8'h00) ? S_TX_DATA : S_IDLE;
                    end
                end
                S_TX_DATA: begin
                    if (TX_READY_I) begin
                        idx <= idx + 1'b1;
                        if (idx == 2'd3) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_dmi_ctrl.sv
// Self-checking bench for uart_dmi_ctrl: FIFO/DMI bus models plus a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_dmi_ctrl;
    localparam int ABITS   = 7;
    localparam int TIMEOUT = 16;

    typedef struct packed { logic [ABITS-1:0] addr; logic [31:0] data; logic [1:0] op; } req_t;
    typedef struct packed { logic [31:0] data; logic [1:0] op; } resp_t;

    logic             CLK_I = 1'b0;
    logic             RST_I = 1'b1;
    logic             RX_EMPTY_I = 1'b1;
    logic             RE_O;
    logic [7:0]       DREC_I = 8'h00;
    logic             TX_READY_I = 1'b1;
    logic             WE_O;
    logic [7:0]       DSEND_O;
    logic             DMI_REQ_VALID_O;
    logic             DMI_REQ_READY_I = 1'b1;
    logic [ABITS-1:0] DMI_REQ_ADDR_O;
    logic [31:0]      DMI_REQ_DATA_O;
    logic [1:0]       DMI_REQ_OP_O;
    logic             DMI_RESP_VALID_I = 1'b0;
    logic             DMI_RESP_READY_O;
    logic [31:0]      DMI_RESP_DATA_I = 32'h0;
    logic [1:0]       DMI_RESP_OP_I = 2'd0;
    logic             BUSY_O;

    uart_dmi_ctrl #(.ABITS(ABITS), .TIMEOUT(TIMEOUT)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .RX_EMPTY_I(RX_EMPTY_I), .RE_O(RE_O), .DREC_I(DREC_I),
        .TX_READY_I(TX_READY_I), .WE_O(WE_O), .DSEND_O(DSEND_O),
        .DMI_REQ_VALID_O(DMI_REQ_VALID_O), .DMI_REQ_READY_I(DMI_REQ_READY_I),
        .DMI_REQ_ADDR_O(DMI_REQ_ADDR_O), .DMI_REQ_DATA_O(DMI_REQ_DATA_O), .DMI_REQ_OP_O(DMI_REQ_OP_O),
        .DMI_RESP_VALID_I(DMI_RESP_VALID_I), .DMI_RESP_READY_O(DMI_RESP_READY_O),
        .DMI_RESP_DATA_I(DMI_RESP_DATA_I), .DMI_RESP_OP_I(DMI_RESP_OP_I), .BUSY_O(BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_fail = 0;
    int proto_err = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_got[$];
    req_t       req_got[$];
    resp_t      resp_q[$];
    logic [7:0] model_in[$];
    resp_t      model_resp[$];
    req_t       exp_req[$];
    logic [7:0] exp_tx[$];
    int last_re_cyc = 0, valid_rise_cyc = 0, resp_take_cyc = 0, first_we_cyc = 0, req_wait_cycles = 0;
    bit we_armed = 0, busy_seen = 0, pop_pend = 0, hs_pend = 0, take_pend = 0;
    bit prev_valid = 0, prev_stalled = 0, resp_wait = 0, arm_tx_stall = 0, rnd_mode = 0;
    req_t prev_req;
    int tx_stall_cnt = 0, req_stall_cnt = 0, resp_delay = 0, resp_delay_cnt = 0;

    // Monitor: samples DUT outputs mid-cycle and logs transfers and protocol violations.
    initial forever begin
        req_t cur;
        @(negedge CLK_I);
        cur = req_t'({DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O});
        if (DMI_REQ_VALID_O && DMI_RESP_READY_O) proto_err++;
        if (RE_O && WE_O) proto_err++;
        if (RE_O && RX_EMPTY_I) proto_err++;
        if (WE_O && !TX_READY_I) proto_err++;
        if (prev_stalled && (!DMI_REQ_VALID_O || cur != prev_req)) proto_err++;
        if (BUSY_O) busy_seen = 1;
        if (RE_O) begin pop_pend = 1; last_re_cyc = cyc; end
        if (WE_O) begin
            tx_got.push_back(DSEND_O);
            if (we_armed) begin first_we_cyc = cyc; we_armed = 0; end
        end
        if (DMI_REQ_VALID_O && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = DMI_REQ_VALID_O;
        if (DMI_REQ_VALID_O && DMI_REQ_READY_I) begin req_got.push_back(cur); hs_pend = 1; end
        if (DMI_REQ_VALID_O && !DMI_REQ_READY_I) req_wait_cycles++;
        prev_stalled = DMI_REQ_VALID_O && !DMI_REQ_READY_I && !RST_I;
        prev_req = cur;
        if (DMI_RESP_READY_O && DMI_RESP_VALID_I) begin take_pend = 1; resp_take_cyc = cyc; we_armed = 1; end
    end

    // Bus models: RX FIFO head, TX FIFO readiness, DMI target.
    initial forever begin
        logic [7:0] tmp;
        resp_t r;
        @(posedge CLK_I); #1;
        cyc++;
        if (pop_pend) begin pop_pend = 0; if (rx_q.size() > 0) tmp = rx_q.pop_front(); end
        RX_EMPTY_I = (rx_q.size() == 0);
        DREC_I = (rx_q.size() > 0) ? rx_q[0] : 8'($urandom);
        if (take_pend) begin
            take_pend = 0;
            DMI_RESP_VALID_I = 1'b0;
            DMI_RESP_DATA_I = $urandom;
            DMI_RESP_OP_I = 2'($urandom);
            if (arm_tx_stall) begin tx_stall_cnt = 50; arm_tx_stall = 0; end
        end
        if (hs_pend) begin hs_pend = 0; resp_wait = 1; resp_delay_cnt = resp_delay; end
        if (resp_wait) begin
            if (resp_delay_cnt > 0) resp_delay_cnt--;
            else begin
                resp_wait = 0;
                if (resp_q.size() > 0) r = resp_q.pop_front();
                else r = '{data: 32'h0, op: 2'd3};
                DMI_RESP_VALID_I = 1'b1;
                DMI_RESP_DATA_I = r.data;
                DMI_RESP_OP_I = r.op;
            end
        end
        if (tx_stall_cnt > 0) begin TX_READY_I = 1'b0; tx_stall_cnt--; end
        else TX_READY_I = rnd_mode ? ($urandom_range(3) != 0) : 1'b1;
        if (DMI_REQ_VALID_O && req_stall_cnt > 0) begin DMI_REQ_READY_I = 1'b0; req_stall_cnt--; end
        else DMI_REQ_READY_I = rnd_mode ? ($urandom_range(2) != 0) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK_I); #3;
    endtask

    task automatic clear_logs();
        tx_got.delete(); req_got.delete(); model_in.delete(); model_resp.delete();
        busy_seen = 0; req_wait_cycles = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_q.push_back(b); model_in.push_back(b);
    endtask

    task automatic push_resp(input logic [31:0] d, input logic [1:0] o);
        resp_t r;
        r.data = d; r.op = o;
        resp_q.push_back(r); model_resp.push_back(r);
    endtask

    function automatic logic [63:0] pack_tx();
        logic [63:0] w;
        w = 64'h0;
        foreach (tx_got[i]) w = {w[55:0], tx_got[i]};
        return w;
    endfunction

    // Reference: walk the byte stream frame by frame, pairing each DMI access with the next response.
    task automatic model_run();
        int i, r;
        logic [7:0] cmd, ab;
        logic [31:0] d;
        resp_t rs;
        exp_req.delete(); exp_tx.delete();
        i = 0; r = 0;
        while (i < model_in.size()) begin
            cmd = model_in[i]; i++;
            if (cmd == 8'h01 || cmd == 8'h02) begin
                ab = model_in[i]; i++;
                d = 32'h0;
                if (cmd == 8'h02) begin
                    for (int k = 0; k < 4; k++) d = d | (32'(model_in[i + k]) << (8 * k));
                    i += 4;
                end
                exp_req.push_back(req_t'({ab[ABITS-1:0], d, (cmd == 8'h01) ? 2'd1 : 2'd2}));
                rs = model_resp[r]; r++;
                exp_tx.push_back({6'b0, rs.op});
                if (cmd == 8'h01 && rs.op == 2'd0)
                    for (int k = 0; k < 4; k++) exp_tx.push_back(8'(rs.data >> (8 * k)));
            end else if (cmd != 8'h00) begin
                exp_tx.push_back(8'hFF);
            end
        end
    endtask

    task automatic wait_done(input int bound, input string name);
        int quiet, n;
        quiet = 0; n = 0;
        while (quiet < 3 && n < bound) begin
            tick(); n++;
            if (rx_q.size() == 0 && !BUSY_O && !resp_wait && !DMI_RESP_VALID_I) quiet++;
            else quiet = 0;
        end
        n_checks++;
        if (quiet < 3) begin
            n_fail++;
            $display("FAIL %s_done: busy=%0d rx_left=%0d after %0d cycles, required idle", name, BUSY_O, rx_q.size(), bound);
        end
    endtask

    task automatic test_reset();
        RST_I = 1'b1;
        rx_q.push_back(8'h00);
        repeat (3) tick();
        n_checks++;
        if ({RE_O, WE_O, DMI_REQ_VALID_O, DMI_RESP_READY_O, BUSY_O} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: re/we/val/rdy/busy=%b required 00000", {RE_O, WE_O, DMI_REQ_VALID_O, DMI_RESP_READY_O, BUSY_O});
        end
        n_checks++;
        if ({DSEND_O, DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: dsend=%h addr=%h data=%h op=%0d required all 0", DSEND_O, DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O);
        end
        RST_I = 1'b0;
        clear_logs();
        repeat (10) tick();
        n_checks++;
        if (rx_q.size() != 0 || busy_seen || tx_got.size() != 0) begin
            n_fail++;
            $display("FAIL zero_byte_ignored: rx_left=%0d busy_seen=%0d tx=%0d required 0 0 0", rx_q.size(), busy_seen, tx_got.size());
        end
    endtask

    task automatic test_write();
        logic [7:0] fr [6];
        fr = '{8'h02, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12};
        clear_logs();
        push_resp(32'h0BAD_F00D, 2'd0);
        foreach (fr[i]) push_byte(fr[i]);
        wait_done(200, "write");
        n_checks++;
        if (req_got.size() != 1 || req_got[0] !== req_t'({7'h10, 32'h12345678, 2'd2})) begin
            n_fail++;
            $display("FAIL write_req: count=%0d first=%h required 1 %h", req_got.size(),
                     (req_got.size() > 0) ? req_got[0] : req_t'(0), req_t'({7'h10, 32'h12345678, 2'd2}));
        end
        n_checks++;
        if (tx_got.size() != 1 || pack_tx() !== 64'h00) begin
            n_fail++;
            $display("FAIL write_tx: count=%0d bytes=%h required 1 00", tx_got.size(), pack_tx());
        end
        n_checks++;
        if (valid_rise_cyc - last_re_cyc != 1) begin
            n_fail++;
            $display("FAIL write_req_latency: %0d cycles required 1", valid_rise_cyc - last_re_cyc);
        end
        n_checks++;
        if (first_we_cyc - resp_take_cyc != 1) begin
            n_fail++;
            $display("FAIL write_tx_latency: %0d cycles required 1", first_we_cyc - resp_take_cyc);
        end
    endtask

    task automatic test_read();
        clear_logs();
        push_resp(32'hDEADBEEF, 2'd0);
        push_byte(8'h01); push_byte(8'h05);
        wait_done(200, "read");
        n_checks++;
        if (req_got.size() != 1 || req_got[0] !== req_t'({7'h05, 32'h0, 2'd1})) begin
            n_fail++;
            $display("FAIL read_req: count=%0d first=%h required 1 %h", req_got.size(),
                     (req_got.size() > 0) ? req_got[0] : req_t'(0), req_t'({7'h05, 32'h0, 2'd1}));
        end
        n_checks++;
        if (tx_got.size() != 5 || pack_tx() !== 64'h00_EF_BE_AD_DE) begin
            n_fail++;
            $display("FAIL read_tx: count=%0d bytes=%h required 5 00efbeadde", tx_got.size(), pack_tx());
        end
        n_checks++;
        if (valid_rise_cyc - last_re_cyc != 1 || first_we_cyc - resp_take_cyc != 1) begin
            n_fail++;
            $display("FAIL read_latency: req=%0d tx=%0d cycles required 1 1", valid_rise_cyc - last_re_cyc, first_we_cyc - resp_take_cyc);
        end
    endtask

    task automatic test_read_fail();
        clear_logs();
        push_resp($urandom, 2'd2);
        push_byte(8'h01); push_byte(8'h7F);
        wait_done(200, "read_fail");
        n_checks++;
        if (tx_got.size() != 1 || pack_tx() !== 64'h02) begin
            n_fail++;
            $display("FAIL read_fail_tx: count=%0d bytes=%h required 1 02", tx_got.size(), pack_tx());
        end
        n_checks++;
        if (BUSY_O !== 1'b0) begin
            n_fail++;
            $display("FAIL read_fail_idle: busy=%b required 0", BUSY_O);
        end
    endtask

    task automatic test_unknown();
        clear_logs();
        push_byte(8'h7A);
        wait_done(100, "unknown");
        n_checks++;
        if (tx_got.size() != 1 || pack_tx() !== 64'hFF) begin
            n_fail++;
            $display("FAIL unknown_tx: count=%0d bytes=%h required 1 ff", tx_got.size(), pack_tx());
        end
        n_checks++;
        if (req_got.size() != 0 || req_wait_cycles != 0) begin
            n_fail++;
            $display("FAIL unknown_no_dmi: requests=%0d required 0", req_got.size() + req_wait_cycles);
        end
        clear_logs();
        push_byte(8'h00);
        repeat (8) tick();
        n_checks++;
        if (tx_got.size() != 0 || busy_seen || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_cmd: tx=%0d busy_seen=%0d rx_left=%0d required 0 0 0", tx_got.size(), busy_seen, rx_q.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] d;
        clear_logs();
        push_byte(8'h02); push_byte(8'h10);
        n = 0;
        while ((rx_q.size() != 0 || pop_pend) && n < 20) begin tick(); n++; end
        n = 0;
        while (cyc < last_re_cyc + TIMEOUT && n < 40) begin tick(); n++; end
        n_checks++;
        if (BUSY_O !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: busy=%b at cycle %0d after last byte, required 1", BUSY_O, cyc - last_re_cyc);
        end
        tick();
        n_checks++;
        if (BUSY_O !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_expire: busy=%b at cycle %0d after last byte, required 0", BUSY_O, cyc - last_re_cyc);
        end
        repeat (5) tick();
        n_checks++;
        if (req_got.size() != 0 || tx_got.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_discard: requests=%0d tx=%0d required 0 0", req_got.size(), tx_got.size());
        end
        d = $urandom;
        clear_logs();
        push_resp(d, 2'd0);
        push_byte(8'h01); push_byte(8'h03);
        wait_done(200, "after_timeout");
        n_checks++;
        if (req_got.size() != 1 || req_got[0] !== req_t'({7'h03, 32'h0, 2'd1})) begin
            n_fail++;
            $display("FAIL after_timeout_req: count=%0d first=%h required 1 %h", req_got.size(),
                     (req_got.size() > 0) ? req_got[0] : req_t'(0), req_t'({7'h03, 32'h0, 2'd1}));
        end
        n_checks++;
        if (tx_got.size() != 5 || pack_tx() !== {24'h0, 8'h00, d[7:0], d[15:8], d[23:16], d[31:24]}) begin
            n_fail++;
            $display("FAIL after_timeout_tx: count=%0d bytes=%h required 5 00%h%h%h%h", tx_got.size(), pack_tx(), d[7:0], d[15:8], d[23:16], d[31:24]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [7:0] ab;
        d = $urandom;
        ab = 8'h80 | 8'($urandom_range(127));
        clear_logs();
        req_stall_cnt = 10;
        arm_tx_stall = 1;
        push_resp(d, 2'd0);
        push_byte(8'h01); push_byte(ab);
        wait_done(500, "backpressure");
        n_checks++;
        if (req_wait_cycles != 10) begin
            n_fail++;
            $display("FAIL bp_req_hold: valid-without-ready cycles=%0d required 10", req_wait_cycles);
        end
        n_checks++;
        if (req_got.size() != 1 || req_got[0] !== req_t'({ab[6:0], 32'h0, 2'd1})) begin
            n_fail++;
            $display("FAIL bp_req: count=%0d first=%h required 1 %h", req_got.size(),
                     (req_got.size() > 0) ? req_got[0] : req_t'(0), req_t'({ab[6:0], 32'h0, 2'd1}));
        end
        n_checks++;
        if (tx_got.size() != 5 || pack_tx() !== {24'h0, 8'h00, d[7:0], d[15:8], d[23:16], d[31:24]}) begin
            n_fail++;
            $display("FAIL bp_tx: count=%0d bytes=%h required 5 00%h%h%h%h", tx_got.size(), pack_tx(), d[7:0], d[15:8], d[23:16], d[31:24]);
        end
        n_checks++;
        if (first_we_cyc - resp_take_cyc != 51) begin
            n_fail++;
            $display("FAIL bp_tx_wait: first byte %0d cycles after response, required 51", first_we_cyc - resp_take_cyc);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        clear_logs();
        req_stall_cnt = 1000;
        push_byte(8'h02); push_byte(8'h44);
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
        n = 0;
        while (!DMI_REQ_VALID_O && n < 30) begin tick(); n++; end
        n_checks++;
        if (DMI_REQ_VALID_O !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup: valid=%b required 1", DMI_REQ_VALID_O);
        end
        RST_I = 1'b1;
        tick();
        n_checks++;
        if ({DMI_REQ_VALID_O, DMI_RESP_READY_O, BUSY_O, WE_O, RE_O} !== 5'b0 || {DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O} !== '0) begin
            n_fail++;
            $display("FAIL abort_txn: val/rdy/busy/we/re=%b addr=%h data=%h op=%0d required all 0",
                     {DMI_REQ_VALID_O, DMI_RESP_READY_O, BUSY_O, WE_O, RE_O}, DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O);
        end
        RST_I = 1'b0;
        req_stall_cnt = 0;
        repeat (5) tick();
        n_checks++;
        if (req_got.size() != 0 || tx_got.size() != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: requests=%0d tx=%0d required 0 0", req_got.size(), tx_got.size());
        end
        push_byte(8'h02); push_byte(8'h55); push_byte(8'hAA);
        n = 0;
        while ((rx_q.size() != 0 || pop_pend) && n < 20) begin tick(); n++; end
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        clear_logs();
        push_resp(32'h0, 2'd0);
        push_byte(8'h01); push_byte(8'h06);
        wait_done(200, "abort_frame");
        n_checks++;
        if (req_got.size() != 1 || req_got[0] !== req_t'({7'h06, 32'h0, 2'd1}) || tx_got.size() != 5) begin
            n_fail++;
            $display("FAIL abort_frame: count=%0d first=%h tx=%0d required 1 %h 5", req_got.size(),
                     (req_got.size() > 0) ? req_got[0] : req_t'(0), tx_got.size(), req_t'({7'h06, 32'h0, 2'd1}));
        end
    endtask

    task automatic test_back_to_back();
        int kind;
        logic [1:0] o;
        clear_logs();
        rnd_mode = 1;
        resp_delay = $urandom_range(3);
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(3);
            case ($urandom_range(2))
                0:       o = 2'd0;
                1:       o = 2'd2;
                default: o = 2'd3;
            endcase
            if (kind == 0) push_byte(8'h00);
            else if (kind == 3) push_byte(8'($urandom_range(255, 3)));
            else begin
                push_byte(8'(kind));
                push_byte(8'($urandom));
                if (kind == 2) for (int k = 0; k < 4; k++) push_byte(8'($urandom));
                push_resp($urandom, o);
            end
        end
        model_run();
        wait_done(20000, "b2b");
        rnd_mode = 0;
        resp_delay = 0;
        n_checks++;
        if (req_got.size() != exp_req.size() || tx_got.size() != exp_tx.size()) begin
            n_fail++;
            $display("FAIL b2b_counts: requests=%0d tx=%0d required %0d %0d", req_got.size(), tx_got.size(), exp_req.size(), exp_tx.size());
        end
        for (int i = 0; i < exp_req.size() && i < req_got.size(); i++) begin
            n_checks++;
            if (req_got[i] !== exp_req[i]) begin
                n_fail++;
                $display("FAIL b2b_req[%0d]: got %h required %h", i, req_got[i], exp_req[i]);
            end
        end
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++) begin
            n_checks++;
            if (tx_got[i] !== exp_tx[i]) begin
                n_fail++;
                $display("FAIL b2b_tx[%0d]: got %h required %h", i, tx_got[i], exp_tx[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_fail();
        test_unknown();
        test_timeout();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        n_checks++;
        if (proto_err != 0) begin
            n_fail++;
            $display("FAIL protocol: %0d handshake/strobe violations seen, required 0", proto_err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_dmi_ctrl.md
UART_DMI_CTRL -- requirements
Module: uart_dmi_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 7, DMI address width (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 100000, inter-byte timeout in clock cycles (>=16).
REQ-003 SHALL have CLK_I  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have RST_I  in  1  reset, synchronous, active-high.
REQ-005 SHALL have RX_EMPTY_I  in  1  UART RX FIFO empty.
REQ-006 SHALL have RE_O  out  1  UART RX FIFO read strobe.
REQ-007 SHALL have DREC_I  in  8  UART RX byte, valid combinationally in the cycle RE_O=1.
REQ-008 SHALL have TX_READY_I  in  1  UART TX FIFO not full.
REQ-009 SHALL have WE_O  out  1  UART TX FIFO write strobe.
REQ-010 SHALL have DSEND_O  out  8  UART TX byte, valid when WE_O=1.
REQ-011 SHALL have DMI_REQ_VALID_O  out  1 / DMI_REQ_READY_I  in  1  DMI request handshake.
REQ-012 SHALL have DMI_REQ_ADDR_O  out  ABITS / DMI_REQ_DATA_O  out  32 / DMI_REQ_OP_O  out  2 (1=read, 2=write).
REQ-013 SHALL have DMI_RESP_VALID_I  in  1 / DMI_RESP_READY_O  out  1  DMI response handshake.
REQ-014 SHALL have DMI_RESP_DATA_I  in  32 / DMI_RESP_OP_I  in  2  response data and status (0 ok, 2 fail, 3 busy).
REQ-015 SHALL have BUSY_O  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RX_ADDR, RX_DATA, DMI_REQ, DMI_RESP, TX_STATUS, TX_DATA.
REQ-017 SHALL assert RE_O only in IDLE/RX_ADDR/RX_DATA and only when RX_EMPTY_I=0, and SHALL sample DREC_I in that same cycle; at most one byte per cycle.
REQ-018 IDLE: byte 0x01 -> read frame, 0x02 -> write frame, next RX_ADDR; byte 0x00 ignored, stay IDLE; any other byte -> load status 0xFF, go TX_STATUS, no DMI access.
REQ-019 RX_ADDR: byte consumed, DREC_I[ABITS-1:0] latched as address, upper bits ignored; read -> DMI_REQ, write -> RX_DATA with byte index 0.
REQ-020 RX_DATA: four bytes consumed LSB first into data[7:0]..data[31:24]; after the fourth -> DMI_REQ.
REQ-021 DMI_REQ: DMI_REQ_VALID_O=1 with stable addr/data/op until the cycle DMI_REQ_READY_I=1, then DMI_RESP; DMI_REQ_DATA_O=0 for reads.
REQ-022 DMI_RESP: DMI_RESP_READY_O=1; on DMI_RESP_VALID_I=1 latch DMI_RESP_DATA_I and status={6'b0,DMI_RESP_OP_I}, go TX_STATUS.
REQ-023 TX_STATUS: WE_O pulsed for one cycle with DSEND_O=status only when TX_READY_I=1, else wait; then TX_DATA if read with status 0x00, else IDLE.
REQ-024 TX_DATA: four bytes of response data sent LSB first, one WE_O per TX_READY_I=1 cycle; after fourth -> IDLE.
REQ-025 Timeout counter SHALL clear on every consumed byte and count every cycle in RX_ADDR/RX_DATA; on reaching TIMEOUT the partial frame SHALL be discarded, state -> IDLE, nothing transmitted.
REQ-026 DMI_REQ, DMI_RESP, TX states SHALL have no timeout; RX FIFO SHALL not be read outside REQ-017 states (backpressure held in UART FIFO).
REQ-027 Latency: last frame byte consumed at cycle N -> DMI_REQ_VALID_O=1 at N+1; response accepted at M -> first WE_O earliest at M+1.
REQ-028 DMI_REQ_VALID_O and DMI_RESP_READY_O SHALL never be high together; WE_O and RE_O are never high in the same cycle.

Reset
REQ-029 On RST_I=1 at a clock edge: state IDLE; RE_O, WE_O, DMI_REQ_VALID_O, DMI_RESP_READY_O, BUSY_O = 0; DSEND_O, DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O = 0; counters and latched data cleared.
REQ-030 Reset mid-frame or mid-transaction SHALL abort immediately; outstanding DMI responses after reset are not accepted until a new request is issued.

Verification
REQ-031 Write: RX bytes 02 10 78 56 34 12, READY=1, resp op 0 -> one request addr 0x10, data 0x12345678, op 2; TX byte 00.
REQ-032 Read: RX bytes 01 05, resp data 0xDEADBEEF op 0 -> request addr 0x05 op 1; TX bytes 00 EF BE AD DE.
REQ-033 Read with resp op 2 -> TX single byte 02, no data bytes, back to IDLE (BUSY_O=0).
REQ-034 Unknown cmd 0x7A -> TX 0xFF, no DMI_REQ_VALID_O; 0x00 -> no TX, BUSY_O stays 0.
REQ-035 Bytes 02 10 then silence, TIMEOUT=16 -> IDLE after 16 idle cycles, no request, no TX; next frame 01 03 processed normally.
REQ-036 TX_READY_I=0 for 50 cycles during read reply, DMI_REQ_READY_I held 0 for 10 cycles -> WE_O and request fields stable/held, no byte lost or duplicated.
